contador_palabras: RTL and testbench

CONTADOR_PALABRAS -- requirements
Module: contador_palabras

---
 rtl/contador_palabras_pkg.sv | 27 ++
 rtl/contador_unidad.sv | 28 ++
 rtl/contador_palabras.sv | 107 ++++++++++
 tb/tb_contador_palabras.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/contador_palabras_pkg.sv
// Shared constants, FSM state encoding and pop-count helper for the
// FIFO word counter.
package contador_palabras_pkg;

    localparam int N_FIFOS   = 4;
    localparam int CNT_W     = 5;
    localparam int IDX_W     = 3;
    localparam int IDX_TOTAL = 4;
    localparam int N_CNT     = N_FIFOS + 1;

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_INIT   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    // Number of FIFOs popped this cycle, widened to the counter width.
    function automatic logic [CNT_W-1:0] pop_count(input logic [N_FIFOS-1:0] pops);
        logic [CNT_W-1:0] sum;
        sum = '0;
        for (int i = 0; i < N_FIFOS; i++) begin
            sum = sum + {{(CNT_W-1){1'b0}}, pops[i]};
        end
        return sum;
    endfunction

endpackage

// File: rtl/contador_unidad.sv
// Single wrapping counter with synchronous clear and a per-cycle
// increment amount.
module contador_unidad
    import contador_palabras_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clr,
    input  logic [CNT_W-1:0] i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    // Clear takes priority; the sum wraps naturally at 2**CNT_W.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + i_inc;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/contador_palabras.sv
// Per-FIFO and total pop counters with a registered, idle-gated read port.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_RESET  | just out of reset, moves to ST_INIT on the next edge
// ST_INIT   | counters held at zero, pops and reads ignored
// ST_ACTIVE | pops counted, reads served while idle=1
module contador_palabras
    import contador_palabras_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             init,
    input  logic             pop_0,
    input  logic             pop_1,
    input  logic             pop_2,
    input  logic             pop_3,
    input  logic             idle,
    input  logic             req,
    input  logic [IDX_W-1:0] idx,
    output logic [CNT_W-1:0] contador,
    output logic             valid
);

    state_t           r_state;
    state_t           w_next;

    logic [N_FIFOS-1:0] w_pops;
    logic               w_clr;
    logic               w_rd;
    logic [CNT_W-1:0]   w_rd_val;
    logic [CNT_W-1:0]   w_cnt [N_CNT];
    logic [CNT_W-1:0]   w_inc [N_CNT];

    logic [CNT_W-1:0]   r_contador;
    logic               r_valid;

    assign w_pops = {pop_3, pop_2, pop_1, pop_0};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_RESET;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_RESET:  w_next = ST_INIT;
            ST_INIT:   w_next = init ? ST_INIT : ST_ACTIVE;
            ST_ACTIVE: w_next = init ? ST_INIT : ST_ACTIVE;
            default:   w_next = ST_RESET;
        endcase
    end

    // Clearing on the edge that enters INIT keeps the counters at zero
    // for the whole time the FSM sits in INIT.
    assign w_clr = (r_state != ST_ACTIVE) || init;

    always_comb begin
        for (int i = 0; i < N_FIFOS; i++) begin
            w_inc[i] = {{(CNT_W-1){1'b0}}, w_pops[i]};
        end
        w_inc[IDX_TOTAL] = pop_count(w_pops);
    end

    for (genvar g = 0; g < N_CNT; g++) begin : g_cnt
        contador_unidad u_cnt (
            .clk   (clk),
            .reset (reset),
            .i_clr (w_clr),
            .i_inc (w_inc[g]),
            .o_cnt (w_cnt[g])
        );
    end

    assign w_rd = (r_state == ST_ACTIVE) && req && idle;

    // Invalid selects fall through to zero.
    always_comb begin
        w_rd_val = '0;
        for (int k = 0; k < N_CNT; k++) begin
            if (idx == IDX_W'(k)) begin
                w_rd_val = w_cnt[k];
            end
        end
    end

    // The mux samples counter values before this edge's pops land.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid    <= 1'b0;
            r_contador <= '0;
        end else begin
            r_valid <= w_rd;
            if (w_rd) begin
                r_contador <= w_rd_val;
            end
        end
    end

    assign contador = r_contador;
    assign valid    = r_valid;

endmodule

// File: tb/tb_contador_palabras.sv
// Directed self-checking bench for contador_palabras.
module tb_contador_palabras;

    logic       clk = 1'b0;
    logic       reset;
    logic       init;
    logic       pop_0, pop_1, pop_2, pop_3;
    logic       idle;
    logic       req;
    logic [2:0] idx;
    logic [4:0] contador;
    logic       valid;

    int n_total = 0;
    int n_pass  = 0;

    contador_palabras dut (
        .clk      (clk),
        .reset    (reset),
        .init     (init),
        .pop_0    (pop_0),
        .pop_1    (pop_1),
        .pop_2    (pop_2),
        .pop_3    (pop_3),
        .idle     (idle),
        .req      (req),
        .idx      (idx),
        .contador (contador),
        .valid    (valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle read with idle=1; checks the strobe and value on the next cycle.
    task automatic rd(input logic [2:0] k, input logic [4:0] exp, input string tag);
        req  = 1'b1;
        idx  = k;
        idle = 1'b1;
        step();
        check({tag, "_valid"}, {7'd0, valid}, 8'd1);
        check({tag, "_val"}, {3'd0, contador}, {3'd0, exp});
        req = 1'b0;
    endtask

    task automatic set_pops(input logic [3:0] p);
        {pop_3, pop_2, pop_1, pop_0} = p;
    endtask

    initial begin
        reset = 1'b0;
        init  = 1'b1;
        set_pops(4'b0000);
        idle  = 1'b0;
        req   = 1'b0;
        idx   = 3'd0;
        #12;
        check("rst_valid", {7'd0, valid}, 8'd0);
        check("rst_cont", {3'd0, contador}, 8'd0);

        // Held in INIT with pop_0 and a pending read: nothing counted or returned.
        @(negedge clk);
        reset = 1'b1;
        set_pops(4'b0001);
        req  = 1'b1;
        idle = 1'b1;
        idx  = 3'd0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("init_no_valid", {7'd0, valid}, 8'd0);
        end
        req = 1'b0;
        set_pops(4'b0000);
        init = 1'b0;
        step();
        rd(3'd0, 5'd0, "init_cnt0");
        rd(3'd4, 5'd0, "init_tot");

        // Mixed pops including two simultaneous-pop edges.
        idle = 1'b0;
        set_pops(4'b0011); step();
        set_pops(4'b0101); step();
        set_pops(4'b0001); step();
        set_pops(4'b0010); step();
        set_pops(4'b0000);
        rd(3'd0, 5'd3, "mix_c0");
        rd(3'd1, 5'd2, "mix_c1");
        rd(3'd2, 5'd1, "mix_c2");
        rd(3'd3, 5'd0, "mix_c3");
        rd(3'd4, 5'd6, "mix_tot");
        step();
        check("quiet_valid", {7'd0, valid}, 8'd0);
        check("quiet_hold", {3'd0, contador}, 8'd6);

        // Back through INIT clears, then 33 pops on FIFO 3 wrap to 1.
        init = 1'b1; step();
        init = 1'b0; step();
        rd(3'd0, 5'd0, "reinit_c0");
        set_pops(4'b1000);
        for (int i = 0; i < 33; i++) step();
        set_pops(4'b0000);
        rd(3'd3, 5'd1, "wrap_c3");
        rd(3'd4, 5'd1, "wrap_tot");

        // Busy request dropped; then four back-to-back strobes with changing idx.
        req  = 1'b1;
        idx  = 3'd2;
        idle = 1'b0;
        step();
        check("busy_valid", {7'd0, valid}, 8'd0);
        check("busy_hold", {3'd0, contador}, 8'd1);
        idle = 1'b1;
        idx = 3'd3; step();
        check("b2b0_valid", {7'd0, valid}, 8'd1);
        check("b2b0_val", {3'd0, contador}, 8'd1);
        idx = 3'd1; step();
        check("b2b1_valid", {7'd0, valid}, 8'd1);
        check("b2b1_val", {3'd0, contador}, 8'd0);
        idx = 3'd4; step();
        check("b2b2_valid", {7'd0, valid}, 8'd1);
        check("b2b2_val", {3'd0, contador}, 8'd1);
        idx = 3'd7; step();
        check("b2b3_valid", {7'd0, valid}, 8'd1);
        check("b2b3_val", {3'd0, contador}, 8'd0);
        req = 1'b0;

        // Snapshot: read of cnt1=4 on the same edge as its fifth pop.
        idle = 1'b0;
        set_pops(4'b0010);
        for (int i = 0; i < 4; i++) step();
        req  = 1'b1;
        idx  = 3'd1;
        idle = 1'b1;
        step();
        set_pops(4'b0000);
        req = 1'b0;
        check("snap_valid", {7'd0, valid}, 8'd1);
        check("snap_val", {3'd0, contador}, 8'd4);
        rd(3'd1, 5'd5, "snap_after");
        rd(3'd6, 5'd0, "bad_idx");
        rd(3'd4, 5'd6, "snap_tot");

        // Reset pulse in the cycle after a request edge.
        req  = 1'b1;
        idx  = 3'd1;
        idle = 1'b1;
        @(posedge clk);
        #1;
        req   = 1'b0;
        reset = 1'b0;
        #2;
        check("midrd_valid", {7'd0, valid}, 8'd0);
        check("midrd_cont", {3'd0, contador}, 8'd0);
        reset = 1'b1;
        set_pops(4'b0100);
        init = 1'b1;
        step();
        step();
        init = 1'b0;
        step();
        step();
        step();
        set_pops(4'b0000);
        rd(3'd2, 5'd2, "post_c2");
        rd(3'd1, 5'd0, "post_c1");
        rd(3'd4, 5'd2, "post_tot");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
